// File: rtl/ip_sched_pkg.sv
// ip_sched_pkg: shared scheduler state type and default watchdog depth
package ip_sched_pkg;
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} sched_state_t;
  localparam int TIMEOUT_DEFAULT = 4096;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: rotating priority encoder returning the first set bit at or above ptr
module rr_picker #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    found = |eligible;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
    end
  end
endmodule

// File: rtl/ip_tx_scheduler.sv
// ip_tx_scheduler: frame-level weighted round-robin grant with stall watchdog
module ip_tx_scheduler
  import ip_sched_pkg::*;
#(
  parameter int S_COUNT = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  localparam int SRC_WIDTH = $clog2(S_COUNT)
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_enable,
  input  logic [S_COUNT*WEIGHT_WIDTH-1:0] i_weight,
  input  logic [S_COUNT-1:0]              i_req,
  output logic [S_COUNT-1:0]              o_grant,
  output logic [SRC_WIDTH-1:0]            o_grant_idx,
  input  logic                            i_hdr_valid,
  input  logic                            i_hdr_ready,
  input  logic                            i_tvalid,
  input  logic                            i_tready,
  input  logic                            i_tlast,
  output logic                            o_timeout,
  output logic [SRC_WIDTH-1:0]            o_timeout_src,
  output logic                            o_busy
);
  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES);
  sched_state_t state, state_d;
  logic [WEIGHT_WIDTH-1:0] credit [S_COUNT];
  logic [S_COUNT-1:0] active, eligible;
  logic [SRC_WIDTH-1:0] rr_ptr, pick_idx;
  logic [WD_WIDTH-1:0] wd;
  logic pick_found, progress, wd_max, do_grant, do_reload, do_done, do_timeout;
  for (genvar i = 0; i < S_COUNT; i++) begin : g_elig
    assign active[i] = i_req[i] && (i_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
    assign eligible[i] = active[i] && (credit[i] != '0);
  end
  rr_picker #(.N(S_COUNT), .W(SRC_WIDTH)) u_picker (
    .eligible(eligible),
    .ptr(rr_ptr),
    .found(pick_found),
    .idx(pick_idx)
  );
  assign wd_max = wd == WD_WIDTH'(TIMEOUT_CYCLES - 1);
  assign o_busy = state != IDLE;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_d;
  end
  // a handshake on the watchdog's last cycle takes precedence over the revoke
  always_comb begin
    state_d = state;
    progress = 1'b0;
    do_grant = 1'b0;
    do_reload = 1'b0;
    do_done = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        do_grant = i_enable && pick_found;
        do_reload = i_enable && !pick_found && (|active);
        state_d = do_grant ? HDR : IDLE;
      end
      HDR: begin
        progress = i_hdr_valid && i_hdr_ready;
        do_timeout = !progress && wd_max;
        state_d = progress ? PAYLOAD : (do_timeout ? IDLE : HDR);
      end
      PAYLOAD: begin
        progress = i_tvalid && i_tready;
        do_done = progress && i_tlast;
        do_timeout = !progress && wd_max;
        state_d = (do_done || do_timeout) ? IDLE : PAYLOAD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_grant <= '0;
      o_grant_idx <= '0;
      o_timeout <= 1'b0;
      o_timeout_src <= '0;
      rr_ptr <= '0;
      wd <= '0;
      for (int j = 0; j < S_COUNT; j++) credit[j] <= '0;
    end else begin
      o_timeout <= do_timeout;
      wd <= (state == IDLE || progress || do_timeout) ? '0 : wd + 1'b1;
      if (do_reload)
        for (int j = 0; j < S_COUNT; j++) credit[j] <= i_weight[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      if (do_grant) begin
        o_grant <= S_COUNT'(1) << pick_idx;
        o_grant_idx <= pick_idx;
        rr_ptr <= (pick_idx == SRC_WIDTH'(S_COUNT - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (do_done || do_timeout) begin
        o_grant <= '0;
        o_grant_idx <= '0;
      end
      if (do_done && credit[o_grant_idx] != '0) credit[o_grant_idx] <= credit[o_grant_idx] - 1'b1;
      if (do_timeout) begin
        o_timeout_src <= o_grant_idx;
        credit[o_grant_idx] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ip_tx_scheduler.sv
// tb_ip_tx_scheduler: randomized frames checked against a credit/pointer reference model
module tb_ip_tx_scheduler;
  localparam int S = 4, WW = 4, TO = 16;
  logic clk = 0, rst_n = 1, en = 0;
  logic [S*WW-1:0] weight = '0;
  logic [S-1:0] req = '0, grant;
  logic [1:0] gidx, tsrc;
  logic hv = 0, hr = 0, tv = 0, tr = 0, tl = 0, tmo, busy;
  int n_cmp = 0, n_bad = 0, ptr = 0, last_tsrc = 0;
  int cred[S], w[S];
  ip_tx_scheduler #(.S_COUNT(S), .WEIGHT_WIDTH(WW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_weight(weight), .i_req(req),
    .o_grant(grant), .o_grant_idx(gidx), .i_hdr_valid(hv), .i_hdr_ready(hr),
    .i_tvalid(tv), .i_tready(tr), .i_tlast(tl), .o_timeout(tmo),
    .o_timeout_src(tsrc), .o_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load_w;
    for (int i = 0; i < S; i++) weight[i*WW +: WW] = WW'(w[i]);
  endtask
  function automatic int pick();
    for (int k = 0; k < S; k++) begin
      int j = (ptr + k) % S;
      if (req[j] && w[j] != 0 && cred[j] > 0) return j;
    end
    return -1;
  endfunction
  task automatic arbitrate(output int idx);
    int lat;
    bit any;
    idx = pick();
    lat = 1;
    if (idx < 0) begin
      any = 0;
      for (int i = 0; i < S; i++) if (req[i] && w[i] != 0) any = 1;
      if (any) begin
        for (int i = 0; i < S; i++) cred[i] = w[i];
        idx = pick();
        lat = 2;
      end else lat = 0;
    end
    if (lat == 0) begin
      repeat (3) begin
        tick;
        check("idle_grant", grant, 0);
        check("idle_busy", busy, 0);
      end
    end else begin
      if (lat == 2) begin
        tick;
        check("reload_grant", grant, 0);
      end
      tick;
      check("grant", grant, 1 << idx);
      check("grant_idx", gidx, idx);
      check("grant_busy", busy, 1);
      ptr = (idx + 1) % S;
    end
  endtask
  task automatic frame(input int idx, input int nbeats, input int mode);
    repeat ($urandom_range(0, 3)) begin
      hv = 1'($urandom); hr = ~hv;
      tick;
      check("hdr_lock", grant, 1 << idx);
    end
    hv = 1; hr = 1;
    tick;
    hv = 0; hr = 0;
    check("hdr_lock", grant, 1 << idx);
    check("hdr_busy", busy, 1);
    if (mode == 1) req = 4'($urandom);
    else if (mode == 2) begin en = 0; req = '0; end
    for (int b = 0; b < nbeats; b++) begin
      repeat ($urandom_range(0, 2)) begin
        tv = 1'($urandom); tr = ~tv; tl = 1'($urandom);
        tick;
        check("pay_lock", grant, 1 << idx);
      end
      tv = 1; tr = 1; tl = (b == nbeats - 1);
      tick;
      tv = 0; tr = 0; tl = 0;
      if (b < nbeats - 1) check("pay_lock", grant, 1 << idx);
    end
    check("end_grant", grant, 0);
    check("end_idx", gidx, 0);
    check("end_busy", busy, 0);
    check("tsrc_hold", tsrc, last_tsrc);
    if (cred[idx] > 0) cred[idx]--;
  endtask
  task automatic stall(input int idx, input bit in_hdr, input bit save);
    if (!in_hdr) begin
      hv = 1; hr = 1;
      tick;
      hv = 0; hr = 0;
    end
    repeat (TO - 1) begin
      tick;
      check("wd_hold", grant, 1 << idx);
      check("wd_quiet", tmo, 0);
    end
    if (save) begin
      if (in_hdr) begin hv = 1; hr = 1; end
      else begin tv = 1; tr = 1; end
      tick;
      hv = 0; hr = 0; tv = 0; tr = 0;
      check("wd_save", tmo, 0);
      check("wd_save_grant", grant, 1 << idx);
      tv = 1; tr = 1; tl = 1;
      tick;
      tv = 0; tr = 0; tl = 0;
      check("save_end", grant, 0);
      if (cred[idx] > 0) cred[idx]--;
    end else begin
      tick;
      check("wd_pulse", tmo, 1);
      check("wd_src", tsrc, idx);
      check("wd_grant", grant, 0);
      check("wd_busy", busy, 0);
      cred[idx] = 0;
      last_tsrc = idx;
      en = 0;
      tick;
      check("wd_pulse_len", tmo, 0);
      en = 1;
    end
  endtask
  initial begin
    int idx, start;
    int cnt[S];
    for (int i = 0; i < S; i++) begin cred[i] = 0; w[i] = 0; cnt[i] = 0; end
    #1 rst_n = 0;
    #2;
    check("rst_grant", grant, 0);
    check("rst_idx", gidx, 0);
    check("rst_busy", busy, 0);
    check("rst_tmo", tmo, 0);
    check("rst_tsrc", tsrc, 0);
    w[0] = 1; load_w; req = 4'b0001; en = 1;
    @(negedge clk) rst_n = 1;
    arbitrate(idx);
    check("single_idx", idx, 0);
    frame(idx, 3, 0);
    for (int i = 0; i < S; i++) w[i] = 1;
    load_w; req = 4'b1111; start = ptr;
    for (int k = 0; k < 8; k++) begin
      arbitrate(idx);
      check("rr_order", idx, (start + k) % S);
      frame(idx, 1, 0);
    end
    w[0] = 3; w[1] = 1; w[2] = 0; w[3] = 0;
    load_w; req = 4'b0111;
    for (int k = 0; k < 8; k++) begin
      arbitrate(idx);
      cnt[idx]++;
      frame(idx, $urandom_range(1, 2), 0);
    end
    check("wrr_src0", cnt[0], 6);
    check("wrr_src1", cnt[1], 2);
    check("wrr_src2", cnt[2], 0);
    for (int i = 0; i < S; i++) w[i] = 1;
    load_w; req = 4'b1111;
    arbitrate(idx);
    frame(idx, 3, 2);
    repeat (3) begin
      tick;
      check("off_grant", grant, 0);
      check("off_busy", busy, 0);
    end
    en = 1;
    req = 4'b0100;
    arbitrate(idx);
    check("wd_pick", idx, 2);
    stall(idx, 0, 0);
    req = 4'b0110;
    arbitrate(idx);
    check("wd_skip", idx, 1);
    frame(idx, 1, 0);
    req = 4'b1111;
    arbitrate(idx);
    stall(idx, 1, 1);
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < S; i++) w[i] = $urandom_range(0, 3);
        load_w;
      end
      if ($urandom_range(0, 2) == 0) req = 4'($urandom);
      arbitrate(idx);
      if (idx < 0) req = 4'($urandom);
      else if ($urandom_range(0, 9) == 0) stall(idx, 1'($urandom), 1'($urandom));
      else frame(idx, $urandom_range(1, 4), 1);
    end
    for (int i = 0; i < S; i++) w[i] = 1;
    load_w; req = 4'b0001;
    arbitrate(idx);
    if (idx >= 0) begin
      hv = 1; hr = 1;
      tick;
      hv = 0; hr = 0; tv = 1; tr = 1;
      tick;
      tv = 0; tr = 0;
    end
    #3 rst_n = 0;
    #1;
    check("arst_grant", grant, 0);
    check("arst_idx", gidx, 0);
    check("arst_busy", busy, 0);
    check("arst_tmo", tmo, 0);
    check("arst_tsrc", tsrc, 0);
    for (int i = 0; i < S; i++) begin cred[i] = 0; w[i] = 0; end
    w[0] = 1; load_w; ptr = 0; last_tsrc = 0; req = 4'b0001; en = 1;
    @(negedge clk) rst_n = 1;
    arbitrate(idx);
    check("arst_regrant", idx, 0);
    frame(idx, 2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
